// File: rtl/hid_pkg.sv
// Shared constants for the HID boot-keyboard decoder.
// Contents: modifier masks, special keycodes, letter range and FSM state type.
package hid_pkg;

    localparam logic [7:0] MOD_CTRL     = 8'h11;
    localparam logic [7:0] MOD_SHIFT    = 8'h22;
    localparam logic [7:0] MOD_ALT      = 8'h44;
    localparam logic [7:0] MOD_META     = 8'h88;

    localparam logic [7:0] KEY_ROLLOVER = 8'h01;
    localparam logic [7:0] KEY_CAPS     = 8'h39;
    localparam logic [7:0] KEY_A        = 8'h04;
    localparam logic [7:0] KEY_Z        = 8'h1D;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    function automatic logic is_letter(input logic [7:0] code);
        return (code >= KEY_A) && (code <= KEY_Z);
    endfunction

endpackage

// File: rtl/hid_layout_es.sv
// Spanish-layout keycode to character map (Latin-1), purely combinational.
// Priority ctrl > alt > meta > shift > none; caps flips letters only when no ctrl/alt/meta is held.
module hid_layout_es
    import hid_pkg::*;
(
    input  logic [7:0] i_code,
    input  logic [7:0] i_mod,
    input  logic       i_caps,
    input  logic       i_nullify,
    output logic [7:0] o_char
);

    logic [7:0] base_c;
    logic [7:0] shift_c;
    logic [7:0] altgr_c;
    logic [7:0] mapped;
    logic       letter;

    always_comb begin
        base_c  = 8'h00;
        shift_c = 8'h00;
        altgr_c = 8'h00;
        letter  = is_letter(i_code);
        if (letter) begin
            base_c  = 8'h61 + (i_code - KEY_A);
            shift_c = 8'h41 + (i_code - KEY_A);
        end
        case (i_code)
            8'h1E: begin base_c = 8'h31; shift_c = 8'h21; altgr_c = 8'h7C; end
            8'h1F: begin base_c = 8'h32; shift_c = 8'h22; altgr_c = 8'h40; end
            8'h20: begin base_c = 8'h33; shift_c = 8'hB7; altgr_c = 8'h23; end
            8'h21: begin base_c = 8'h34; shift_c = 8'h24; altgr_c = 8'h7E; end
            8'h22: begin base_c = 8'h35; shift_c = 8'h25; end
            8'h23: begin base_c = 8'h36; shift_c = 8'h26; altgr_c = 8'hAC; end
            8'h24: begin base_c = 8'h37; shift_c = 8'h2F; end
            8'h25: begin base_c = 8'h38; shift_c = 8'h28; end
            8'h26: begin base_c = 8'h39; shift_c = 8'h29; end
            8'h27: begin base_c = 8'h30; shift_c = 8'h3D; end
            8'h28: begin base_c = 8'h0D; shift_c = 8'h0D; end
            8'h29: begin base_c = 8'h1B; shift_c = 8'h1B; end
            8'h2A: begin base_c = 8'h08; shift_c = 8'h08; end
            8'h2B: begin base_c = 8'h09; shift_c = 8'h09; end
            8'h2C: begin base_c = 8'h20; shift_c = 8'h20; end
            8'h2D: begin base_c = 8'h27; shift_c = 8'h3F; end
            8'h2E: begin base_c = 8'hA1; shift_c = 8'hBF; end
            8'h2F: begin base_c = 8'h60; shift_c = 8'h5E; altgr_c = 8'h5B; end
            8'h30: begin base_c = 8'h2B; shift_c = 8'h2A; altgr_c = 8'h5D; end
            8'h31: begin base_c = 8'hE7; shift_c = 8'hC7; altgr_c = 8'h7D; end
            8'h33: begin base_c = 8'hF1; shift_c = 8'hD1; end
            8'h34: begin base_c = 8'hB4; shift_c = 8'hA8; altgr_c = 8'h7B; end
            8'h35: begin base_c = 8'hBA; shift_c = 8'hAA; altgr_c = 8'h5C; end
            8'h36: begin base_c = 8'h2C; shift_c = 8'h3B; end
            8'h37: begin base_c = 8'h2E; shift_c = 8'h3A; end
            8'h38: begin base_c = 8'h2D; shift_c = 8'h5F; end
            8'h64: begin base_c = 8'h3C; shift_c = 8'h3E; end
            default: ;
        endcase

        // Ctrl only yields the C0 control codes for letters (Ctrl+A = 0x01).
        if ((i_mod & MOD_CTRL) != 8'h00)
            mapped = letter ? (i_code - 8'h03) : 8'h00;
        else if ((i_mod & MOD_ALT) != 8'h00)
            mapped = altgr_c;
        else if ((i_mod & MOD_META) != 8'h00)
            mapped = 8'h00;
        else if ((i_mod & MOD_SHIFT) != 8'h00)
            mapped = (letter && i_caps) ? base_c : shift_c;
        else
            mapped = (letter && i_caps) ? shift_c : base_c;

        o_char = ((mapped == 8'h00) && !i_nullify) ? i_code : mapped;
    end

endmodule

// File: rtl/hid_key_decoder.sv
// HID boot-report to character stream: slot k of a report accepted at T is pushed at edge T+1+k.
// Reports are only taken in IDLE; a full FIFO with no pop drops the character and sets o_overflow.
module hid_key_decoder
    import hid_pkg::*;
#(
    parameter int N_SLOTS    = 6,
    parameter int FIFO_DEPTH = 8,
    parameter int DELAY_CYC  = 12_000_000,
    parameter int RATE_CYC   = 1_200_000,
    parameter int NULLIFY    = 1
)(
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_rpt_valid,
    output logic                   o_rpt_ready,
    input  logic [7:0]             i_mod,
    input  logic [8*N_SLOTS-1:0]   i_keys,
    output logic [7:0]             o_byte,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic                   o_caps,
    output logic                   o_overflow,
    input  logic                   i_ovf_clr
);

    localparam int SW = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
    localparam int PW = $clog2(FIFO_DEPTH);

    state_t               state_q, state_d;
    logic [SW-1:0]        slot_q, slot_d;
    logic [7:0]           mod_q, mod_d;
    logic [8*N_SLOTS-1:0] keys_q, keys_d;
    logic [8*N_SLOTS-1:0] prev_q, prev_d;
    logic                 caps_q, caps_d;
    logic                 new_seen_q, new_seen_d;
    logic [7:0]           cand_key_q, cand_key_d;
    logic                 cand_ok_q, cand_ok_d;
    logic                 rpt_act_q, rpt_act_d;
    logic [7:0]           rpt_key_q, rpt_key_d;
    logic                 rpt_pend_q, rpt_pend_d;
    logic [31:0]          timer_q, timer_d;
    logic [PW-1:0]        wr_q, wr_d, rd_q, rd_d;
    logic [PW:0]          cnt_q, cnt_d;
    logic                 ovf_q, ovf_d;
    logic [7:0]           fifo_mem_q [FIFO_DEPTH];

    logic [7:0] cur_code;
    logic [7:0] map_code;
    logic [7:0] map_char;
    logic       in_prev, slot_new;
    logic       rpt_rollover, rpt_held, rpt_expire;
    logic       push_req, do_push, pop, full, ovf_evt;
    logic [7:0] push_dat;

    assign cur_code   = keys_q[{slot_q, 3'b000} +: 8];
    assign map_code   = (state_q == ST_SCAN) ? cur_code : rpt_key_q;
    assign rpt_expire = rpt_act_q && (timer_q <= 32'd1);

    hid_layout_es u_layout (
        .i_code    (map_code),
        .i_mod     (mod_q),
        .i_caps    (caps_q),
        .i_nullify (NULLIFY != 0),
        .o_char    (map_char)
    );

    always_comb begin
        in_prev      = 1'b0;
        rpt_rollover = 1'b1;
        rpt_held     = 1'b0;
        for (int k = 0; k < N_SLOTS; k++) begin
            if (prev_q[8*k +: 8] == cur_code) in_prev = 1'b1;
            if (i_keys[8*k +: 8] != KEY_ROLLOVER) rpt_rollover = 1'b0;
            if (i_keys[8*k +: 8] == rpt_key_q) rpt_held = 1'b1;
        end
        slot_new = (cur_code != 8'h00) && (cur_code != KEY_ROLLOVER) && !in_prev;
    end

    always_comb begin
        state_d    = state_q;
        slot_d     = slot_q;
        mod_d      = mod_q;
        keys_d     = keys_q;
        prev_d     = prev_q;
        caps_d     = caps_q;
        new_seen_d = new_seen_q;
        cand_key_d = cand_key_q;
        cand_ok_d  = cand_ok_q;
        rpt_act_d  = rpt_act_q;
        rpt_key_d  = rpt_key_q;
        rpt_pend_d = rpt_pend_q | rpt_expire;
        timer_d    = timer_q;
        push_req   = 1'b0;
        push_dat   = 8'h00;

        if (rpt_expire)
            timer_d = 32'(RATE_CYC);
        else if (rpt_act_q)
            timer_d = timer_q - 32'd1;

        case (state_q)
            ST_IDLE: begin
                // An expiry that landed during SCAN is emitted here, using the latest modifiers.
                if (rpt_pend_q) begin
                    push_req   = (map_char != 8'h00);
                    push_dat   = map_char;
                    rpt_pend_d = rpt_expire;
                end
                if (i_rpt_valid && !rpt_rollover) begin
                    state_d    = ST_SCAN;
                    slot_d     = '0;
                    mod_d      = i_mod;
                    keys_d     = i_keys;
                    new_seen_d = 1'b0;
                    cand_key_d = 8'h00;
                    cand_ok_d  = 1'b0;
                    if (rpt_act_q && !rpt_held) begin
                        rpt_act_d  = 1'b0;
                        rpt_pend_d = 1'b0;
                    end
                end
            end
            ST_SCAN: begin
                if (slot_new) begin
                    new_seen_d = 1'b1;
                    cand_key_d = cur_code;
                    if (cur_code == KEY_CAPS) begin
                        caps_d    = !caps_q;
                        cand_ok_d = 1'b0;
                    end else begin
                        push_req  = (map_char != 8'h00);
                        push_dat  = map_char;
                        cand_ok_d = (map_char != 8'h00);
                    end
                end
                if (slot_q == SW'(N_SLOTS - 1)) begin
                    state_d = ST_IDLE;
                    prev_d  = keys_q;
                    if (new_seen_d) begin
                        rpt_key_d  = cand_key_d;
                        rpt_act_d  = cand_ok_d;
                        rpt_pend_d = 1'b0;
                        timer_d    = 32'(DELAY_CYC);
                    end
                end else begin
                    slot_d = slot_q + SW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pop     = (cnt_q != '0) && i_ready;
        full    = (cnt_q == (PW+1)'(FIFO_DEPTH));
        do_push = push_req && (!full || pop);
        ovf_evt = push_req && full && !pop;
        wr_d    = do_push ? wr_q + PW'(1) : wr_q;
        rd_d    = pop ? rd_q + PW'(1) : rd_q;
        cnt_d   = cnt_q + (PW+1)'(do_push) - (PW+1)'(pop);
        ovf_d   = (ovf_q && !i_ovf_clr) || ovf_evt;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            slot_q     <= '0;
            mod_q      <= 8'h00;
            keys_q     <= '0;
            prev_q     <= '0;
            caps_q     <= 1'b0;
            new_seen_q <= 1'b0;
            cand_key_q <= 8'h00;
            cand_ok_q  <= 1'b0;
            rpt_act_q  <= 1'b0;
            rpt_key_q  <= 8'h00;
            rpt_pend_q <= 1'b0;
            timer_q    <= 32'd0;
            wr_q       <= '0;
            rd_q       <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            slot_q     <= slot_d;
            mod_q      <= mod_d;
            keys_q     <= keys_d;
            prev_q     <= prev_d;
            caps_q     <= caps_d;
            new_seen_q <= new_seen_d;
            cand_key_q <= cand_key_d;
            cand_ok_q  <= cand_ok_d;
            rpt_act_q  <= rpt_act_d;
            rpt_key_q  <= rpt_key_d;
            rpt_pend_q <= rpt_pend_d;
            timer_q    <= timer_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst_n && do_push) fifo_mem_q[wr_q] <= push_dat;
    end

    assign o_rpt_ready = (state_q == ST_IDLE);
    assign o_valid     = (cnt_q != '0);
    assign o_byte      = (cnt_q != '0) ? fifo_mem_q[rd_q] : 8'h00;
    assign o_caps      = caps_q;
    assign o_overflow  = ovf_q;

endmodule

// File: tb/tb_hid_key_decoder.sv
// Directed bench for hid_key_decoder with short repeat timing (delay 20, rate 5).
module tb_hid_key_decoder;

    logic        clk;
    logic        rst_n;
    logic        rpt_valid;
    logic        rpt_ready;
    logic [7:0]  mod;
    logic [47:0] keys;
    logic [7:0]  o_byte;
    logic        o_valid;
    logic        i_ready;
    logic        o_caps;
    logic        o_overflow;
    logic        ovf_clr;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int t0;

    hid_key_decoder #(
        .N_SLOTS    (6),
        .FIFO_DEPTH (8),
        .DELAY_CYC  (20),
        .RATE_CYC   (5),
        .NULLIFY    (1)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_rpt_valid (rpt_valid),
        .o_rpt_ready (rpt_ready),
        .i_mod       (mod),
        .i_keys      (keys),
        .o_byte      (o_byte),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_caps      (o_caps),
        .o_overflow  (o_overflow),
        .i_ovf_clr   (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [47:0] k6(input logic [7:0] a = 8'h00, input logic [7:0] b = 8'h00,
                                       input logic [7:0] c = 8'h00, input logic [7:0] d = 8'h00,
                                       input logic [7:0] e = 8'h00, input logic [7:0] f = 8'h00);
        return {f, e, d, c, b, a};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int guard = 0;
        while (!rpt_ready && guard < 100) begin
            tick(1);
            guard++;
        end
        chk_eq("idle_wait", 32'(rpt_ready), 1);
    endtask

    task automatic send(input logic [7:0] m, input logic [47:0] k);
        wait_idle();
        mod       = m;
        keys      = k;
        rpt_valid = 1'b1;
        tick(1);
        rpt_valid = 1'b0;
    endtask

    task automatic press_release(input logic [7:0] m, input logic [47:0] k);
        send(m, k);
        send(8'h00, k6());
        wait_idle();
    endtask

    task automatic pop(input string tag, input logic [7:0] exp);
        chk_eq({tag, "_vld"}, 32'(o_valid), 1);
        chk_eq(tag, 32'(o_byte), 32'(exp));
        i_ready = 1'b1;
        tick(1);
        i_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        rpt_valid = 1'b0;
        mod       = 8'h00;
        keys      = '0;
        i_ready   = 1'b0;
        ovf_clr   = 1'b0;
        tick(3);
        chk_eq("rst_ready", 32'(rpt_ready), 1);
        chk_eq("rst_valid", 32'(o_valid), 0);
        chk_eq("rst_byte", 32'(o_byte), 0);
        chk_eq("rst_caps", 32'(o_caps), 0);
        chk_eq("rst_ovf", 32'(o_overflow), 0);
        rst_n = 1'b1;
        tick(1);

        // Two new keys: latency of the first character, then order.
        send(8'h00, k6(8'h04, 8'h05));
        chk_eq("lat_t0_vld", 32'(o_valid), 0);
        chk_eq("lat_t0_rdy", 32'(rpt_ready), 0);
        tick(1);
        chk_eq("lat_t1_vld", 32'(o_valid), 1);
        chk_eq("lat_t1_byte", 32'(o_byte), 32'h61);
        send(8'h00, k6());
        wait_idle();
        pop("ab_0", 8'h61);
        pop("ab_1", 8'h62);
        chk_eq("ab_empty", 32'(o_valid), 0);

        // Held key: same report twice, then three repeats before release.
        send(8'h00, k6(8'h04));
        t0 = cyc;
        send(8'h00, k6(8'h04));
        wait_idle();
        while (cyc < t0 + 37) tick(1);
        send(8'h00, k6());
        wait_idle();
        for (int i = 0; i < 4; i++) pop($sformatf("rpt_%0d", i), 8'h61);
        chk_eq("rpt_count", 32'(o_valid), 0);
        tick(30);
        chk_eq("rpt_stopped", 32'(o_valid), 0);

        // Caps lock interaction with shift.
        press_release(8'h00, k6(8'h39));
        chk_eq("caps_on", 32'(o_caps), 1);
        chk_eq("caps_nopush", 32'(o_valid), 0);
        press_release(8'h02, k6(8'h04));
        pop("caps_shift", 8'h61);
        press_release(8'h00, k6(8'h04));
        pop("caps_plain", 8'h41);
        press_release(8'h00, k6(8'h39));
        chk_eq("caps_off", 32'(o_caps), 0);

        // Layout samples: digit, n-tilde, space, unmapped; ctrl beats shift; AltGr; meta.
        press_release(8'h00, k6(8'h1E, 8'h33, 8'h2C, 8'h68));
        pop("map_1", 8'h31);
        pop("map_ntilde", 8'hF1);
        pop("map_space", 8'h20);
        chk_eq("map_unmapped", 32'(o_valid), 0);
        press_release(8'h03, k6(8'h06));
        pop("map_ctrl_c", 8'h03);
        press_release(8'h40, k6(8'h1F));
        pop("map_altgr_at", 8'h40);
        press_release(8'h08, k6(8'h04));
        chk_eq("map_meta", 32'(o_valid), 0);

        // Overflow: nine characters into an eight-entry FIFO.
        send(8'h00, k6(8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09));
        wait_idle();
        chk_eq("ovf_pre", 32'(o_overflow), 0);
        send(8'h00, k6(8'h0A, 8'h0B, 8'h0C));
        send(8'h00, k6());
        wait_idle();
        chk_eq("ovf_set", 32'(o_overflow), 1);
        for (int i = 0; i < 8; i++) pop($sformatf("ovf_%0d", i), 8'(8'h61 + i));
        chk_eq("ovf_empty", 32'(o_valid), 0);
        chk_eq("ovf_sticky", 32'(o_overflow), 1);
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        chk_eq("ovf_clr", 32'(o_overflow), 0);

        // Rollover report between two identical reports keeps the repeat running.
        send(8'h00, k6(8'h04));
        t0 = cyc;
        send(8'h00, k6(8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01));
        send(8'h00, k6(8'h04));
        wait_idle();
        while (cyc < t0 + 32) tick(1);
        send(8'h00, k6());
        wait_idle();
        for (int i = 0; i < 3; i++) pop($sformatf("roll_%0d", i), 8'h61);
        chk_eq("roll_count", 32'(o_valid), 0);

        // Reset two edges into a six-key scan.
        press_release(8'h00, k6(8'h39));
        chk_eq("mid_caps", 32'(o_caps), 1);
        send(8'h00, k6(8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09));
        tick(1);
        chk_eq("mid_pre_vld", 32'(o_valid), 1);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        chk_eq("mid_vld", 32'(o_valid), 0);
        chk_eq("mid_byte", 32'(o_byte), 0);
        chk_eq("mid_rdy", 32'(rpt_ready), 1);
        chk_eq("mid_caps_clr", 32'(o_caps), 0);
        tick(10);
        chk_eq("mid_no_push", 32'(o_valid), 0);
        press_release(8'h00, k6(8'h04));
        pop("mid_prev_clr", 8'h61);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
